// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
// Provides default widths, the BCD saturation limit, the converter FSM
// state type and the BCD digit type.
package calc_pkg;

    localparam int unsigned BIN_W_DEF  = 14;
    localparam int unsigned DIGITS_DEF = 4;

    // Largest value representable with the given number of BCD digits.
    function automatic int unsigned calc_bcd_max(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int unsigned BCD_MAX = calc_bcd_max(DIGITS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/module_bcd_adjust.sv
// Double-dabble correction step: every BCD digit >= 5 gets +3 so that
// the following left shift carries correctly into the next digit.
// Ports:
//   i_bcd   - packed BCD digits, digit 0 in [3:0]
//   o_adj_c - corrected digits (combinational)
module module_bcd_adjust
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic [4*DIGITS-1:0] o_adj_c
);

    always_comb begin
        bcd_digit_t d;
        o_adj_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = i_bcd[4*i +: 4];
            o_adj_c[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
        end
    end

endmodule

// File: rtl/module_bin_to_bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter with start/done
// handshake. Inputs above the BCD range saturate and raise o_ovf.
// A start arriving while busy is kept in a one-deep pending slot
// (most recent wins) and launched straight out of DONE.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   i_bin      - binary value, sampled when a start is accepted
//   i_start    - start request pulse
//   o_bcd      - registered BCD result, digit 0 in [3:0]
//   o_done     - one-cycle pulse when o_bcd/o_ovf update
//   o_busy     - conversion in progress
//   o_ovf      - input exceeded the BCD range (registered with o_bcd)
module module_bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    i_bin,
    input  logic                i_start,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_done,
    output logic                o_busy,
    output logic                o_ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned MAX_V = calc_bcd_max(DIGITS);

    state_t                   state, state_nxt;
    logic [BCD_W-1:0]         scratch;
    logic [BIN_W-1:0]         bin_sr;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_cur;
    logic                     pend_vld;
    logic [BIN_W-1:0]         pend_val;
    logic                     pend_ovf;

    logic                     ovf_c;
    logic [BIN_W-1:0]         sat_c;
    logic [BIN_W-1:0]         ld_val_c;
    logic                     ld_ovf_c;
    logic                     restart_c;
    logic                     load_c;
    logic                     shift_c;
    logic                     done_nxt;
    logic                     busy_nxt;
    logic [BCD_W-1:0]         adj_c;
    logic [BCD_W+BIN_W-1:0]   sh_c;

    // Saturate the incoming value to the displayable range.
    always_comb begin
        ovf_c = (32'(i_bin) > MAX_V);
        sat_c = ovf_c ? BIN_W'(MAX_V) : i_bin;
    end

    // A fresh start in DONE supersedes anything already pending.
    always_comb begin
        restart_c = pend_vld || i_start;
        ld_val_c  = (state == DONE && !i_start) ? pend_val : sat_c;
        ld_ovf_c  = (state == DONE && !i_start) ? pend_ovf : ovf_c;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = restart_c ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs and next values of the registered handshake.
    always_comb begin
        load_c   = 1'b0;
        shift_c  = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = o_busy;
        case (state)
            IDLE: begin
                if (i_start) begin
                    load_c   = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
            end
            DONE: begin
                done_nxt = 1'b1;
                load_c   = restart_c;
                busy_nxt = restart_c;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    module_bcd_adjust #(.DIGITS(DIGITS)) u_adjust (
        .i_bcd   (scratch),
        .o_adj_c (adj_c)
    );

    assign sh_c = {adj_c, bin_sr} << 1;

    // Datapath, pending slot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch  <= '0;
            bin_sr   <= '0;
            cnt      <= '0;
            ovf_cur  <= 1'b0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            pend_ovf <= 1'b0;
            o_bcd    <= '0;
            o_ovf    <= 1'b0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_done <= done_nxt;
            o_busy <= busy_nxt;

            if (load_c) begin
                scratch <= '0;
                bin_sr  <= ld_val_c;
                ovf_cur <= ld_ovf_c;
                cnt     <= CNT_W'(BIN_W);
            end else if (shift_c) begin
                scratch <= sh_c[BCD_W+BIN_W-1:BIN_W];
                bin_sr  <= sh_c[BIN_W-1:0];
                cnt     <= cnt - CNT_W'(1);
            end

            if (state == DONE) begin
                o_bcd <= scratch;
                o_ovf <= ovf_cur;
            end

            if (load_c) begin
                pend_vld <= 1'b0;
            end else if (i_start && state == SHIFT) begin
                pend_vld <= 1'b1;
                pend_val <= sat_c;
                pend_ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// Directed self-checking bench for module_bin_to_bcd_seq.
module tb_module_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic [13:0] i_bin;
    logic        i_start;
    logic [15:0] o_bcd;
    logic        o_done;
    logic        o_busy;
    logic        o_ovf;

    int n_cmp;
    int n_err;
    int lat;
    logic [15:0] held_bcd;
    logic        unstable;

    module_bin_to_bcd_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_bin   (i_bin),
        .i_start (i_start),
        .o_bcd   (o_bcd),
        .o_done  (o_done),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a start for exactly one sampling edge; returns #1 after it.
    task automatic do_start(input logic [13:0] v);
        @(negedge clk);
        i_bin   = v;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count edges until o_done is seen; -1 on timeout. Flags o_bcd changes before done.
    task automatic wait_done(output int n);
        n = -1;
        held_bcd = o_bcd;
        unstable = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (o_done) begin
                n = e;
                break;
            end
            if (o_bcd !== held_bcd) unstable = 1'b1;
        end
    endtask

    logic [13:0] bv_in  [4];
    logic [15:0] bv_bcd [4];
    logic        bv_ovf [4];

    initial begin
        int n_done;
        int done_e [2];
        logic [15:0] done_v [2];
        logic busy_drop;

        n_cmp = 0;
        n_err = 0;
        rst_n   = 1'b0;
        i_bin   = '0;
        i_start = 1'b0;

        // 1: reset state and quiet idle
        #23;
        check_eq("rst_bcd", 32'(o_bcd), 32'h0);
        check_eq("rst_done", 32'(o_done), 32'h0);
        check_eq("rst_busy", 32'(o_busy), 32'h0);
        check_eq("rst_ovf", 32'(o_ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (o_done) n_done++;
        end
        check_eq("idle_no_done", 32'(n_done), 32'h0);

        // 2: basic conversion
        do_start(14'd1234);
        check_eq("busy_after_start", 32'(o_busy), 32'h1);
        wait_done(lat);
        check_eq("lat_1234", 32'(lat), 32'd15);
        check_eq("bcd_1234", 32'(o_bcd), 32'h1234);
        check_eq("ovf_1234", 32'(o_ovf), 32'h0);
        check_eq("busy_in_done", 32'(o_busy), 32'h0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(o_done), 32'h0);

        // 3: boundary values
        bv_in[0] = 14'd0;     bv_bcd[0] = 16'h0000; bv_ovf[0] = 1'b0;
        bv_in[1] = 14'd9999;  bv_bcd[1] = 16'h9999; bv_ovf[1] = 1'b0;
        bv_in[2] = 14'd10000; bv_bcd[2] = 16'h9999; bv_ovf[2] = 1'b1;
        bv_in[3] = 14'd16383; bv_bcd[3] = 16'h9999; bv_ovf[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_start(bv_in[i]);
            wait_done(lat);
            check_eq($sformatf("lat_b%0d", i), 32'(lat), 32'd15);
            check_eq($sformatf("bcd_b%0d", i), 32'(o_bcd), 32'(bv_bcd[i]));
            check_eq($sformatf("ovf_b%0d", i), 32'(o_ovf), 32'(bv_ovf[i]));
        end

        // 4: starts while busy, latest pending wins
        do_start(14'd42);
        n_done = 0;
        busy_drop = 1'b0;
        done_e[0] = 0; done_e[1] = 0;
        done_v[0] = '0; done_v[1] = '0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (o_done) begin
                if (n_done < 2) begin
                    done_e[n_done] = e;
                    done_v[n_done] = o_bcd;
                end
                n_done++;
            end
            if (e < 30 && !o_busy) busy_drop = 1'b1;
            if (e == 30) check_eq("busy_after_restart", 32'(o_busy), 32'h0);
            if (e == 5) begin i_bin = 14'd77; i_start = 1'b1; end
            if (e == 8) begin i_bin = 14'd88; i_start = 1'b1; end
        end
        check_eq("pend_done_count", 32'(n_done), 32'd2);
        check_eq("pend_first_edge", 32'(done_e[0]), 32'd15);
        check_eq("pend_first_bcd", 32'(done_v[0]), 32'h0042);
        check_eq("pend_second_edge", 32'(done_e[1]), 32'd30);
        check_eq("pend_second_bcd", 32'(done_v[1]), 32'h0088);
        check_eq("pend_busy_held", 32'(busy_drop), 32'h0);

        // 5: asynchronous reset mid-conversion
        do_start(14'd500);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_bcd", 32'(o_bcd), 32'h0);
        check_eq("arst_busy", 32'(o_busy), 32'h0);
        check_eq("arst_done", 32'(o_done), 32'h0);
        check_eq("arst_ovf", 32'(o_ovf), 32'h0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (o_done) n_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (o_done) n_done++;
        end
        check_eq("arst_no_done", 32'(n_done), 32'h0);
        do_start(14'd7);
        wait_done(lat);
        check_eq("lat_7", 32'(lat), 32'd15);
        check_eq("bcd_7", 32'(o_bcd), 32'h0007);

        // 6: back-to-back start in the done cycle
        do_start(14'd321);
        wait_done(lat);
        check_eq("lat_321", 32'(lat), 32'd15);
        check_eq("bcd_321", 32'(o_bcd), 32'h0321);
        i_bin   = 14'd654;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check_eq("b2b_accept_busy", 32'(o_busy), 32'h1);
        wait_done(lat);
        check_eq("b2b_spacing", 32'(lat + 1), 32'd16);
        check_eq("b2b_stable", 32'(unstable), 32'h0);
        check_eq("bcd_654", 32'(o_bcd), 32'h0654);
        check_eq("ovf_654", 32'(o_ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
